// File: rtl/axis_mm_pkg.sv
// -----------------------------------------------------------------------------
// axis_mm_pkg
// Shared constants for the byte-stream command link. The host-side bridge
// (mm2axis) and the stream-side decoder both import this package, so the
// command opcodes and AXI response codes are defined in exactly one place.
//
// Contents:
//   CMD_NOP / CMD_READ / CMD_WRITE  first byte of every link command
//   RESP_OKAY / RESP_SLVERR         AXI response codes used by the bridge
//   byte_of()                       extracts byte lane idx of a 32-bit word
// -----------------------------------------------------------------------------
package axis_mm_pkg;

    localparam logic [7:0] CMD_NOP   = 8'h00;
    localparam logic [7:0] CMD_READ  = 8'h01;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Byte lane idx of a little-endian 32-bit word (lane 0 = bits [7:0]).
    function automatic logic [7:0] byte_of(input logic [31:0] word,
                                           input logic [1:0]  idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mm2axis.sv
// -----------------------------------------------------------------------------
// mm2axis
// AXI4-Lite slave that turns every access into a command on the byte-stream
// link (m_axis) and collects read replies from the return stream (s_axis).
//
// Link wire format, LSB byte first:
//   write: CMD_WRITE, A[7:0], A[15:8], D[7:0], D[15:8], D[23:16], D[31:24]
//   read : CMD_READ,  A[7:0], A[15:8]   reply: D[7:0] .. D[31:24]
//
// Ports:
//   aclk, aresetn          clock, synchronous active-low reset
//   s_axi_aw* / s_axi_w*   write address / data channels (1-entry holding regs)
//   s_axi_b*               write response
//   s_axi_ar* / s_axi_r*   read address / read data + response
//   m_axis_*               outgoing command bytes (registered tvalid/tdata)
//   s_axis_*               incoming reply bytes (tready registered, always 1)
//   stray_byte             1-cycle pulse: RX byte accepted outside a reply phase
//
// Parameters:
//   TIMEOUT_CYCLES  idle cycles allowed per reply byte before the read is
//                   aborted with SLVERR; 0 waits forever.
// -----------------------------------------------------------------------------
module mm2axis
    import axis_mm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        aclk,
    input  logic        aresetn,

    input  logic [31:0] s_axi_awaddr,
    input  logic [2:0]  s_axi_awprot,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,

    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,

    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,

    input  logic [31:0] s_axi_araddr,
    input  logic [2:0]  s_axi_arprot,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,

    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,

    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,

    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,

    output logic        stray_byte
);

    // Timer is wide enough to hold TIMEOUT_CYCLES itself; keep at least 1 bit
    // so the "wait forever" configuration still elaborates.
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

    // TX_DATA / RX_DATA cover the four data bytes; byte_idx_q selects the lane.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX_CMD,
        ST_TX_A0,
        ST_TX_A1,
        ST_TX_DATA,
        ST_RX_DATA,
        ST_B_RESP,
        ST_R_RESP
    } state_e;

    state_e        state_q,    state_d;
    logic          is_wr_q,    is_wr_d;      // command in flight is a write
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [TW-1:0] tmr_q,      tmr_d;

    // Holding registers, one entry per address/data channel.
    logic          aw_full_q,  aw_full_d;
    logic [31:0]   aw_addr_q,  aw_addr_d;
    logic          w_full_q,   w_full_d;
    logic [31:0]   w_data_q,   w_data_d;
    logic [3:0]    w_strb_q,   w_strb_d;
    logic          ar_full_q,  ar_full_d;
    logic [31:0]   ar_addr_q,  ar_addr_d;

    // Registered outputs.
    logic          tx_valid_q, tx_valid_d;
    logic [7:0]    tx_data_q,  tx_data_d;
    logic          rx_ready_q, rx_ready_d;
    logic          bvalid_q,   bvalid_d;
    logic [1:0]    bresp_q,    bresp_d;
    logic          rvalid_q,   rvalid_d;
    logic [1:0]    rresp_q,    rresp_d;
    logic [31:0]   rdata_q,    rdata_d;
    logic          stray_q,    stray_d;

    logic          aw_hs, w_hs, ar_hs, tx_hs, rx_hs;
    logic [15:0]   link_addr;

    // Protection bits have no meaning on the link.
    logic          unused_prot;
    assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

    assign s_axi_awready = aresetn & ~aw_full_q;
    assign s_axi_wready  = aresetn & ~w_full_q;
    assign s_axi_arready = aresetn & ~ar_full_q;

    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;
    assign m_axis_tvalid = tx_valid_q;
    assign m_axis_tdata  = tx_data_q;
    assign s_axis_tready = rx_ready_q;
    assign stray_byte    = stray_q;

    assign aw_hs = s_axi_awvalid & s_axi_awready;
    assign w_hs  = s_axi_wvalid  & s_axi_wready;
    assign ar_hs = s_axi_arvalid & s_axi_arready;
    assign tx_hs = tx_valid_q    & m_axis_tready;
    assign rx_hs = s_axis_tvalid & rx_ready_q;

    assign link_addr = is_wr_q ? aw_addr_q[15:0] : ar_addr_q[15:0];

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d    = state_q;
        is_wr_d    = is_wr_q;
        byte_idx_d = byte_idx_q;
        tmr_d      = tmr_q;
        aw_full_d  = aw_full_q;
        aw_addr_d  = aw_addr_q;
        w_full_d   = w_full_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        ar_full_d  = ar_full_q;
        ar_addr_d  = ar_addr_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        rx_ready_d = 1'b1;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        rvalid_d   = rvalid_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;
        stray_d    = 1'b0;

        // Channels latch independently; ready is low while full, so a latch
        // and the release below can never coincide for the same register.
        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_addr_d = s_axi_awaddr;
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = s_axi_wdata;
            w_strb_d = s_axi_wstrb;
        end
        if (ar_hs) begin
            ar_full_d = 1'b1;
            ar_addr_d = s_axi_araddr;
        end

        // Return-stream bytes are always accepted; outside a reply they are
        // dropped and flagged.
        if (rx_hs && state_q != ST_RX_DATA) begin
            stray_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                // A complete write wins over a pending read.
                if (aw_full_q && w_full_q) begin
                    if (aw_addr_q[31:16] != 16'h0000) begin
                        bvalid_d = 1'b1;
                        bresp_d  = RESP_SLVERR;
                        state_d  = ST_B_RESP;
                    end else if (w_strb_q == 4'b0000) begin
                        // Nothing to write: acknowledge without touching the link.
                        bvalid_d = 1'b1;
                        bresp_d  = RESP_OKAY;
                        state_d  = ST_B_RESP;
                    end else begin
                        // Link has no byte enables; the whole word is sent.
                        is_wr_d    = 1'b1;
                        tx_valid_d = 1'b1;
                        tx_data_d  = CMD_WRITE;
                        state_d    = ST_TX_CMD;
                    end
                end else if (ar_full_q) begin
                    if (ar_addr_q[31:16] != 16'h0000) begin
                        rvalid_d = 1'b1;
                        rresp_d  = RESP_SLVERR;
                        rdata_d  = 32'h0;
                        state_d  = ST_R_RESP;
                    end else begin
                        is_wr_d    = 1'b0;
                        tx_valid_d = 1'b1;
                        tx_data_d  = CMD_READ;
                        state_d    = ST_TX_CMD;
                    end
                end
            end

            // TX states name the byte currently presented on m_axis; each
            // handshake loads the following byte so there is no bubble.
            ST_TX_CMD: begin
                if (tx_hs) begin
                    tx_data_d = link_addr[7:0];
                    state_d   = ST_TX_A0;
                end
            end

            ST_TX_A0: begin
                if (tx_hs) begin
                    tx_data_d = link_addr[15:8];
                    state_d   = ST_TX_A1;
                end
            end

            ST_TX_A1: begin
                if (tx_hs) begin
                    byte_idx_d = 2'd0;
                    if (is_wr_q) begin
                        tx_data_d = byte_of(w_data_q, 2'd0);
                        state_d   = ST_TX_DATA;
                    end else begin
                        tx_valid_d = 1'b0;
                        tmr_d      = '0;
                        state_d    = ST_RX_DATA;
                    end
                end
            end

            ST_TX_DATA: begin
                if (tx_hs) begin
                    if (byte_idx_q == 2'd3) begin
                        tx_valid_d = 1'b0;
                        bvalid_d   = 1'b1;
                        bresp_d    = RESP_OKAY;
                        state_d    = ST_B_RESP;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        tx_data_d  = byte_of(w_data_q, byte_idx_q + 2'd1);
                    end
                end
            end

            ST_RX_DATA: begin
                if (rx_hs) begin
                    // Shift in from the top: after four bytes the first one
                    // received sits in [7:0]. rvalid is low meanwhile.
                    rdata_d = {s_axis_tdata, rdata_q[31:8]};
                    tmr_d   = '0;
                    if (byte_idx_q == 2'd3) begin
                        rvalid_d = 1'b1;
                        rresp_d  = RESP_OKAY;
                        state_d  = ST_R_RESP;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end else if (TIMEOUT_CYCLES != 0) begin
                    if (tmr_q == TMO_MAX) begin
                        // Peer went silent: drop partial bytes and fail the read.
                        rvalid_d = 1'b1;
                        rresp_d  = RESP_SLVERR;
                        rdata_d  = 32'h0;
                        state_d  = ST_R_RESP;
                    end else begin
                        tmr_d = tmr_q + TW'(1);
                    end
                end
            end

            ST_B_RESP: begin
                if (bvalid_q && s_axi_bready) begin
                    bvalid_d  = 1'b0;
                    aw_full_d = 1'b0;
                    w_full_d  = 1'b0;
                    state_d   = ST_IDLE;
                end
            end

            ST_R_RESP: begin
                if (rvalid_q && s_axi_rready) begin
                    rvalid_d  = 1'b0;
                    ar_full_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            is_wr_q    <= 1'b0;
            byte_idx_q <= 2'd0;
            tmr_q      <= '0;
            aw_full_q  <= 1'b0;
            w_full_q   <= 1'b0;
            ar_full_q  <= 1'b0;
            // NOTE: the holding-register payloads are only read while their
            // full flag is set, but they are cleared anyway so a reset leaves
            // no stale address or data visible in debug.
            aw_addr_q  <= 32'h0;
            w_data_q   <= 32'h0;
            w_strb_q   <= 4'h0;
            ar_addr_q  <= 32'h0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            rx_ready_q <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= 32'h0;
            stray_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_wr_q    <= is_wr_d;
            byte_idx_q <= byte_idx_d;
            tmr_q      <= tmr_d;
            aw_full_q  <= aw_full_d;
            w_full_q   <= w_full_d;
            ar_full_q  <= ar_full_d;
            aw_addr_q  <= aw_addr_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            ar_addr_q  <= ar_addr_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            rx_ready_q <= rx_ready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            stray_q    <= stray_d;
        end
    end

endmodule
